// File: rtl/conv_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : conv_result_streamer
//  Brief    : Snapshots a packed result matrix on start and streams it out
//             element by element in row-major order over a valid/ready
//             handshake, with end-of-row / end-of-matrix markers and
//             one-cycle done / err pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module conv_result_streamer #(
  parameter int ELEM_W  = 16,
  parameter int MAX_DIM = 5
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [2:0]                        res_m,
  input  logic [2:0]                        res_n,
  input  logic                              res_err,
  input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] convResult,
  output logic [ELEM_W-1:0]                 out_data,
  output logic [2:0]                        out_row,
  output logic [2:0]                        out_col,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_eol,
  output logic                              out_last,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic [4:0]                        sent_count
);

  localparam int c_SNAP_W = MAX_DIM * MAX_DIM * ELEM_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [c_SNAP_W-1:0] r_snap;
  logic [2:0]          r_m;
  logic [2:0]          r_n;
  logic [2:0]          r_row;
  logic [2:0]          r_col;
  logic [4:0]          r_cnt;

  logic                w_accept;
  logic                w_dim_bad;
  logic                w_xfer;
  logic                w_col_end;
  logic                w_row_end;
  logic [ELEM_W-1:0]   w_data;

  // A start is only honoured in IDLE; anywhere else it is simply dropped.
  assign w_accept  = (r_state == ST_IDLE) && start;

  // Reject empty, oversized or producer-flagged matrices.
  assign w_dim_bad = res_err
                   || (res_m == 3'd0)
                   || (res_n == 3'd0)
                   || (32'(res_m) > MAX_DIM)
                   || (32'(res_n) > MAX_DIM);

  assign w_xfer    = (r_state == ST_SEND) && out_ready;
  assign w_col_end = (r_col == (r_n - 3'd1));
  assign w_row_end = (r_row == (r_m - 3'd1));

  // State register; reset dominates start and any pending transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and status outputs, all derived from the current state.
  always_comb begin
    w_next    = r_state;
    out_valid = 1'b0;
    out_eol   = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = w_dim_bad ? ST_ERR : ST_SEND;
        end
      end
      ST_SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_eol   = w_col_end;
        out_last  = w_col_end && w_row_end;
        if (out_ready && w_col_end && w_row_end) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      ST_ERR: begin
        err    = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Snapshot capture, row/column walk and transfer counter. The snapshot is
  // taken on every start seen in IDLE (including rejected ones); the count
  // is cleared there too so a rejected start reports zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_snap <= '0;
      r_m    <= 3'd0;
      r_n    <= 3'd0;
      r_row  <= 3'd0;
      r_col  <= 3'd0;
      r_cnt  <= 5'd0;
    end else if (w_accept) begin
      r_snap <= convResult;
      r_m    <= res_m;
      r_n    <= res_n;
      r_row  <= 3'd0;
      r_col  <= 3'd0;
      r_cnt  <= 5'd0;
    end else if (w_xfer) begin
      r_cnt <= r_cnt + 5'd1;
      if (w_col_end) begin
        r_col <= 3'd0;
        r_row <= r_row + 3'd1;
      end else begin
        r_col <= r_col + 3'd1;
      end
    end
  end

  // Element select from the snapshot; coordinates outside the matrix read 0.
  always_comb begin
    w_data = '0;
    for (int r = 0; r < MAX_DIM; r++) begin
      for (int c = 0; c < MAX_DIM; c++) begin
        if ((r_row == 3'(r)) && (r_col == 3'(c))) begin
          w_data = r_snap[(r*MAX_DIM+c)*ELEM_W +: ELEM_W];
        end
      end
    end
  end

  assign out_data   = w_data;
  assign out_row    = r_row;
  assign out_col    = r_col;
  assign sent_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_conv_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_result_streamer
//  Brief    : Scoreboard bench for conv_result_streamer. Stimulus pushes the
//             row-major element sequence of each accepted matrix; a monitor
//             pops and compares on every handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_result_streamer;

  localparam int EW = 16;
  localparam int MD = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [2:0]          res_m;
  logic [2:0]          res_n;
  logic                res_err;
  logic [MD*MD*EW-1:0] convResult;
  logic [EW-1:0]       out_data;
  logic [2:0]          out_row;
  logic [2:0]          out_col;
  logic                out_valid;
  logic                out_ready;
  logic                out_eol;
  logic                out_last;
  logic                busy;
  logic                done;
  logic                err;
  logic [4:0]          sent_count;

  conv_result_streamer #(.ELEM_W(EW), .MAX_DIM(MD)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .res_m      (res_m),
    .res_n      (res_n),
    .res_err    (res_err),
    .convResult (convResult),
    .out_data   (out_data),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_eol    (out_eol),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .sent_count (sent_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [EW-1:0] data;
    logic [7:0]    meta;   // {row, col, eol, last}
  } exp_t;

  exp_t          sb[$];
  int            errors = 0;
  int            checks = 0;
  int            n_xfer = 0;
  int            ready_mode = 0;
  int            pat_idx = 0;
  logic [EW-1:0] mat [MD][MD];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ready pattern generator: 0 = always ready, 1 = random, 2 = 1,0,0,1 repeating.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: begin
        out_ready = ((pat_idx % 4) == 0) || ((pat_idx % 4) == 3);
        pat_idx++;
      end
    endcase
  end

  // Monitor: checks stall stability and pops the scoreboard on each transfer.
  logic [EW-1:0] p_data;
  logic [7:0]    p_meta;
  bit            p_stall = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      p_stall = 1'b0;
    end else if (out_valid) begin
      if (p_stall) begin
        chk("stall_data", 32'(out_data), 32'(p_data));
        chk("stall_meta", 32'({out_row, out_col, out_eol, out_last}), 32'(p_meta));
      end
      if (out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: got data %0h with empty scoreboard at %0t", out_data, $time);
        end else begin
          e = sb.pop_front();
          chk("xfer_data", 32'(out_data), 32'(e.data));
          chk("xfer_meta", 32'({out_row, out_col, out_eol, out_last}), 32'(e.meta));
        end
        n_xfer++;
      end
      p_data  = out_data;
      p_meta  = {out_row, out_col, out_eol, out_last};
      p_stall = !out_ready;
    end else begin
      p_stall = 1'b0;
    end
  end

  task automatic fill_rand();
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++)
        mat[r][c] = EW'($urandom);
  endtask

  // Expected stream: every element of the m x n window in row-major order.
  task automatic push_exp(input int m, input int n);
    exp_t e;
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < n; c++) begin
        e.data = mat[r][c];
        e.meta = {3'(r), 3'(c), (c == n-1), (r == m-1) && (c == n-1)};
        sb.push_back(e);
      end
    end
  endtask

  task automatic issue_start(input int m, input int n, input bit rerr);
    @(posedge clk); #1;
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++)
        convResult[(r*MD+c)*EW +: EW] = mat[r][c];
    res_m   = 3'(m);
    res_n   = 3'(n);
    res_err = rerr;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic run(input int m, input int n, input bit rerr, input int rmode, input bit disturb);
    bit bad;
    int cyc;
    ready_mode = rmode;
    bad = rerr || (m == 0) || (n == 0) || (m > MD) || (n > MD);
    if (!bad) push_exp(m, n);
    issue_start(m, n, rerr);
    if (bad) begin
      chk("err_pulse", 32'(err), 32'd1);
      chk("err_no_valid", 32'(out_valid), 32'd0);
      chk("err_count", 32'(sent_count), 32'd0);
      @(posedge clk); #1;
      chk("err_one_cycle", 32'({err, out_valid, busy}), 32'd0);
    end else begin
      chk("first_valid_latency", 32'(out_valid), 32'd1);
      cyc = 0;
      while (!done && cyc < 1000) begin
        if (disturb && cyc == 5) begin
          convResult = {MD*MD{16'hDEAD}};
          start = 1'b1;
        end
        if (disturb && cyc == 6) start = 1'b0;
        @(posedge clk); #1;
        cyc++;
      end
      chk("done_seen", 32'(done), 32'd1);
      if (rmode == 0) chk("throughput_cycles", 32'(cyc), 32'(m*n));
      chk("done_count", 32'(sent_count), 32'(m*n));
      chk("done_status", 32'({out_valid, busy, err}), 32'b010);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      @(posedge clk); #1;
      chk("idle_after_done", 32'({done, busy, out_valid}), 32'd0);
      @(posedge clk); #1;
      chk("idle_hold_count", 32'(sent_count), 32'(m*n));
      chk("idle_no_valid", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    int cyc;
    int base;
    reset = 1'b1; start = 1'b0; res_m = 3'd0; res_n = 3'd0; res_err = 1'b0;
    convResult = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", 32'({out_valid, out_eol, out_last, busy, done, err}), 32'd0);
    chk("reset_data", 32'({out_data, out_row, out_col, sent_count}), 32'd0);
    reset = 1'b0;

    // 2x3 with elements 1..6, always ready.
    fill_rand();
    for (int i = 0; i < 6; i++) mat[i/3][i%3] = EW'(i + 1);
    run(2, 3, 1'b0, 0, 1'b0);

    // 1x1 single element.
    fill_rand();
    mat[0][0] = 16'hBEEF;
    run(1, 1, 1'b0, 0, 1'b0);

    // 5x5 with the 1,0,0,1 ready pattern.
    fill_rand();
    run(5, 5, 1'b0, 2, 1'b0);

    // Rejections.
    run(2, 2, 1'b1, 0, 1'b0);
    run(2, 6, 1'b0, 0, 1'b0);
    run(0, 3, 1'b0, 0, 1'b0);
    run(6, 1, 1'b0, 0, 1'b0);

    // Input change and extra start mid-stream.
    fill_rand();
    run(5, 5, 1'b0, 1, 1'b1);

    // Reset after four transfers of a 3x3 stream.
    fill_rand();
    ready_mode = 0;
    base = n_xfer;
    push_exp(3, 3);
    issue_start(3, 3, 1'b0);
    cyc = 0;
    while (n_xfer < base + 4 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("four_xfers", 32'(n_xfer - base), 32'd4);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_flags", 32'({out_valid, out_eol, out_last, busy, done, err}), 32'd0);
    chk("abort_data", 32'({out_data, out_row, out_col, sent_count}), 32'd0);
    chk("abort_left", 32'(sb.size()), 32'd5);
    sb.delete();
    reset = 1'b0;
    fill_rand();
    run(3, 3, 1'b0, 0, 1'b0);

    // Random dimensions with random back-pressure.
    for (int k = 0; k < 8; k++) begin
      fill_rand();
      run($urandom_range(1, MD), $urandom_range(1, MD), 1'b0, 1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
